vga_write_arbiter: RTL

// - Shares the single VGA adapter pixel-write port between N_REQ pixel producers
//   (sprite/entity drawer, background clear, overlay/score writer, end screens).
// - Round-robin grant with burst lock: the owner keeps the port until it flags last

---
 rtl/vga_write_arbiter_pkg.sv | 29 ++
 rtl/vga_write_arbiter_if.sv | 41 ++++
 rtl/vga_write_arbiter_rr_pick.sv | 42 ++++
 rtl/vga_write_arbiter.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/vga_write_arbiter_pkg.sv
// Shared definitions for the VGA write arbiter.
//   - Default coordinate/colour widths for the 160x120 RGB-111 adapter
//   - Screen limits (informational; the arbiter never clips)
//   - FSM state encodings
//   - next_index(): round-robin successor of a requester index
package vga_write_arbiter_pkg;

  localparam int DEF_X_W = 8;
  localparam int DEF_Y_W = 7;
  localparam int DEF_C_W = 3;

  localparam int SCREEN_X_MAX = 159;
  localparam int SCREEN_Y_MAX = 119;

  // grant_id is always 3 bits wide, so up to 8 requesters are addressable.
  localparam int GRANT_W = 3;

  localparam logic [0:0] ARB_IDLE  = 1'b0;
  localparam logic [0:0] ARB_BURST = 1'b1;

  // (idx + 1) mod n, for idx < n <= 8
  function automatic logic [GRANT_W-1:0] next_index(input logic [GRANT_W-1:0] idx,
                                                    input int n);
    logic [GRANT_W:0] s;
    s = {1'b0, idx} + 4'd1;
    return (s >= 4'(n)) ? 3'd0 : s[GRANT_W-1:0];
  endfunction

endpackage

// File: rtl/vga_write_arbiter_if.sv
// Pixel-write bus between the producers and the arbiter, plus the adapter side.
//   pause / req_valid / req_last / req_x / req_y / req_c : producer -> arbiter
//   req_ready                                          : arbiter -> producers
//   plot / xToVGA / yToVGA / cToVGA                    : arbiter -> VGA adapter
//   grant_id / busy / timeout_err                      : arbiter status
// Modports: master = producer/adapter side, slave = arbiter.
interface vga_write_arbiter_if
  import vga_write_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int X_W   = DEF_X_W,
  parameter int Y_W   = DEF_Y_W,
  parameter int C_W   = DEF_C_W
);

  logic                   pause;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_last;
  logic [N_REQ*X_W-1:0]   req_x;
  logic [N_REQ*Y_W-1:0]   req_y;
  logic [N_REQ*C_W-1:0]   req_c;
  logic [N_REQ-1:0]       req_ready;
  logic                   plot;
  logic [X_W-1:0]         xToVGA;
  logic [Y_W-1:0]         yToVGA;
  logic [C_W-1:0]         cToVGA;
  logic [GRANT_W-1:0]     grant_id;
  logic                   busy;
  logic                   timeout_err;

  modport master (
    output pause, req_valid, req_last, req_x, req_y, req_c,
    input  req_ready, plot, xToVGA, yToVGA, cToVGA, grant_id, busy, timeout_err
  );

  modport slave (
    input  pause, req_valid, req_last, req_x, req_y, req_c,
    output req_ready, plot, xToVGA, yToVGA, cToVGA, grant_id, busy, timeout_err
  );

endinterface

// File: rtl/vga_write_arbiter_rr_pick.sv
// Combinational round-robin search.
//   req : request vector (N_REQ bits)
//   ptr : index searched first (< N_REQ)
//   idx : first set request found in order ptr, ptr+1, ... mod N_REQ
//   any : at least one request set
module vga_write_arbiter_rr_pick
  import vga_write_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]   req,
  input  logic [GRANT_W-1:0] ptr,
  output logic [GRANT_W-1:0] idx,
  output logic               any
);

  // Padding to 8 bits lets a 3-bit index select without width games.
  logic [7:0]         req_pad;
  logic [GRANT_W-1:0] cand [N_REQ];

  assign req_pad = 8'(req);

  // cand[gi] = (ptr + gi) mod N_REQ, the gi-th position in search order.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
    logic [GRANT_W:0] sum;
    assign sum      = {1'b0, ptr} + 4'(gi);
    assign cand[gi] = (sum >= 4'(N_REQ)) ? 3'(sum - 4'(N_REQ)) : sum[GRANT_W-1:0];
  end

  // Walk from the back so the earliest position in search order wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_pad[cand[k]]) begin
        idx = cand[k];
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin, burst-locked arbiter for the single VGA adapter write port.
//   clock, reset : system clock, synchronous active-high reset
//   bus (slave)  : producer requests in, ready/plot/x/y/colour/status out
// The owner keeps the port until a pixel flagged last is accepted or the
// watchdog sees TIMEOUT unpaused cycles without a transfer. Pixel outputs
// are registered: plot follows an accepted pixel by one cycle.
module vga_write_arbiter
  import vga_write_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int C_W     = DEF_C_W,
  parameter int TIMEOUT = 255
) (
  input logic            clock,
  input logic            reset,
  vga_write_arbiter_if.slave bus
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [0:0]         state_q,  state_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GRANT_W-1:0] grant_q,  grant_d;
  logic [WD_W-1:0]    wd_q,     wd_d;
  logic               plot_q,   plot_d;
  logic [X_W-1:0]     x_q,      x_d;
  logic [Y_W-1:0]     y_q,      y_d;
  logic [C_W-1:0]     c_q,      c_d;
  logic               terr_q,   terr_d;

  logic [GRANT_W-1:0] pick_idx;
  logic               pick_any;
  logic [7:0]         valid_pad, last_pad;
  logic               sel_valid, sel_last;
  logic [X_W-1:0]     sel_x;
  logic [Y_W-1:0]     sel_y;
  logic [C_W-1:0]     sel_c;
  logic               xfer;

  vga_write_arbiter_rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Only the owner can see ready, and only while not paused.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign bus.req_ready[gi] = (state_q == ARB_BURST) && !bus.pause &&
                               (grant_q == 3'(gi));
  end

  // Owner's request fields.
  assign valid_pad = 8'(bus.req_valid);
  assign last_pad  = 8'(bus.req_last);
  assign sel_valid = valid_pad[grant_q];
  assign sel_last  = last_pad[grant_q];

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    sel_c = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == 3'(i)) begin
        sel_x = bus.req_x[i*X_W +: X_W];
        sel_y = bus.req_y[i*Y_W +: Y_W];
        sel_c = bus.req_c[i*C_W +: C_W];
      end
    end
  end

  assign xfer = (state_q == ARB_BURST) && !bus.pause && sel_valid;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    wd_d     = wd_q;
    plot_d   = 1'b0;
    x_d      = x_q;
    y_d      = y_q;
    c_d      = c_q;
    terr_d   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (!bus.pause && pick_any) begin
          grant_d = pick_idx;
          wd_d    = '0;
          state_d = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (xfer) begin
          plot_d = 1'b1;
          x_d    = sel_x;
          y_d    = sel_y;
          c_d    = sel_c;
          wd_d   = '0;
          if (sel_last) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = next_index(grant_q, N_REQ);
          end
        end else if (!bus.pause) begin
          // This is the TIMEOUT-th stalled cycle: release the port.
          if (wd_q == WD_W'(TIMEOUT - 1)) begin
            state_d  = ARB_IDLE;
            rr_ptr_d = next_index(grant_q, N_REQ);
            terr_d   = 1'b1;
            wd_d     = '0;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      wd_q     <= '0;
      plot_q   <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      c_q      <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      wd_q     <= wd_d;
      plot_q   <= plot_d;
      x_q      <= x_d;
      y_q      <= y_d;
      c_q      <= c_d;
      terr_q   <= terr_d;
    end
  end

  assign bus.plot        = plot_q;
  assign bus.xToVGA      = x_q;
  assign bus.yToVGA      = y_q;
  assign bus.cToVGA      = c_q;
  assign bus.grant_id    = grant_q;
  assign bus.busy        = (state_q == ARB_BURST);
  assign bus.timeout_err = terr_q;

endmodule
